// File: rtl/clock_pkg.sv
// Shared constants and mode encoding for the 12-hour clock controller.
package clock_pkg;

  localparam int unsigned HOUR_W = 4;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned MODE_W = 2;

  localparam logic [HOUR_W-1:0] HOUR_MIN = HOUR_W'(1);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(12);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
  // Stepping off this hour crosses noon/midnight and flips AM/PM.
  localparam logic [HOUR_W-1:0] HOUR_PM_EDGE = HOUR_MAX - HOUR_W'(1);

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

endpackage

// File: rtl/time_advance.sv
// Combinational next hours/minutes/pm for one minute or hour step.
module time_advance
  import clock_pkg::*;
(
  input  logic [HOUR_W-1:0] hours,
  input  logic [MIN_W-1:0]  minutes,
  input  logic              pm,
  input  logic              inc_hour,
  input  logic              inc_min,
  input  logic              carry_en,
  output logic [HOUR_W-1:0] hours_next,
  output logic [MIN_W-1:0]  minutes_next,
  output logic              pm_next
);

  logic hour_step;

  always_comb begin
    hours_next   = hours;
    minutes_next = minutes;
    pm_next      = pm;
    hour_step    = inc_hour;

    if (inc_min) begin
      if (minutes == MIN_MAX) begin
        minutes_next = '0;
        hour_step    = hour_step | carry_en;
      end else begin
        minutes_next = minutes + MIN_W'(1);
      end
    end

    if (hour_step) begin
      if (hours == HOUR_MAX) begin
        hours_next = HOUR_MIN;
      end else begin
        hours_next = hours + HOUR_W'(1);
      end
      if (hours == HOUR_PM_EDGE) begin
        pm_next = ~pm;
      end
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// RUN / SET_HOUR / SET_MIN controller holding the 12-hour time, with
// field blink and a seconds-clear pulse on leaving SET_MIN.
module clock_set_controller
  import clock_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_second,
  input  logic              enable_minute,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic              pm,
  output logic [MODE_W-1:0] mode,
  output logic              blank_hours,
  output logic              blank_minutes,
  output logic              sec_clear
);

  mode_e             mode_q, mode_d;
  logic [HOUR_W-1:0] hours_q, hours_d;
  logic [MIN_W-1:0]  minutes_q, minutes_d;
  logic              pm_q, pm_d;
  logic              phase_q, phase_d;
  logic              blank_hours_q, blank_hours_d;
  logic              blank_minutes_q, blank_minutes_d;
  logic              sec_clear_q, sec_clear_d;

  logic              inc_hour, inc_min, carry_en;
  logic [HOUR_W-1:0] adv_hours;
  logic [MIN_W-1:0]  adv_minutes;
  logic              adv_pm;

  time_advance u_time_advance (
    .hours        (hours_q),
    .minutes      (minutes_q),
    .pm           (pm_q),
    .inc_hour     (inc_hour),
    .inc_min      (inc_min),
    .carry_en     (carry_en),
    .hours_next   (adv_hours),
    .minutes_next (adv_minutes),
    .pm_next      (adv_pm)
  );

  // Next-state: btn_mode always wins over btn_inc and enable_second.
  always_comb begin
    mode_d      = mode_q;
    phase_d     = phase_q;
    sec_clear_d = 1'b0;
    inc_hour    = 1'b0;
    inc_min     = 1'b0;
    carry_en    = 1'b0;

    case (mode_q)
      MODE_RUN: begin
        inc_min  = enable_minute;
        carry_en = 1'b1;
        phase_d  = 1'b0;
        if (btn_mode) begin
          mode_d = MODE_SET_HOUR;
        end
      end
      MODE_SET_HOUR: begin
        if (btn_mode) begin
          mode_d  = MODE_SET_MIN;
          phase_d = 1'b0;
        end else begin
          inc_hour = btn_inc;
          if (enable_second) begin
            phase_d = ~phase_q;
          end
        end
      end
      MODE_SET_MIN: begin
        if (btn_mode) begin
          mode_d      = MODE_RUN;
          phase_d     = 1'b0;
          sec_clear_d = 1'b1;
        end else begin
          inc_min = btn_inc;
          if (enable_second) begin
            phase_d = ~phase_q;
          end
        end
      end
      default: begin
        mode_d  = MODE_RUN;
        phase_d = 1'b0;
      end
    endcase

    hours_d         = adv_hours;
    minutes_d       = adv_minutes;
    pm_d            = adv_pm;
    blank_hours_d   = (mode_d == MODE_SET_HOUR) & phase_d;
    blank_minutes_d = (mode_d == MODE_SET_MIN) & phase_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q          <= MODE_RUN;
      hours_q         <= HOUR_MAX;
      minutes_q       <= '0;
      pm_q            <= 1'b0;
      phase_q         <= 1'b0;
      blank_hours_q   <= 1'b0;
      blank_minutes_q <= 1'b0;
      sec_clear_q     <= 1'b0;
    end else begin
      mode_q          <= mode_d;
      hours_q         <= hours_d;
      minutes_q       <= minutes_d;
      pm_q            <= pm_d;
      phase_q         <= phase_d;
      blank_hours_q   <= blank_hours_d;
      blank_minutes_q <= blank_minutes_d;
      sec_clear_q     <= sec_clear_d;
    end
  end

  assign hours         = hours_q;
  assign minutes       = minutes_q;
  assign pm            = pm_q;
  assign mode          = mode_q;
  assign blank_hours   = blank_hours_q;
  assign blank_minutes = blank_minutes_q;
  assign sec_clear     = sec_clear_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller: stimulus queues expected
// output snapshots tagged with the cycle they must appear on.
module tb_clock_set_controller;

  logic       clk;
  logic       reset;
  logic       enable_second;
  logic       enable_minute;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic       pm;
  logic [1:0] mode;
  logic       blank_hours;
  logic       blank_minutes;
  logic       sec_clear;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  clock_set_controller dut (
    .clk           (clk),
    .reset         (reset),
    .enable_second (enable_second),
    .enable_minute (enable_minute),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .hours         (hours),
    .minutes       (minutes),
    .pm            (pm),
    .mode          (mode),
    .blank_hours   (blank_hours),
    .blank_minutes (blank_minutes),
    .sec_clear     (sec_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // Drive one sampled cycle of inputs, shortly after the active edge.
  task automatic step(input logic bm, input logic bi, input logic em,
                      input logic es, input logic rst = 1'b0);
    @(posedge clk);
    #1;
    btn_mode      = bm;
    btn_inc       = bi;
    enable_minute = em;
    enable_second = es;
    reset         = rst;
  endtask

  // Expected outputs after the edge that samples the inputs just driven.
  task automatic exp_o(input string name, input int h, input int m, input int p,
                       input int md, input int bh, input int bmn, input int sc);
    exp_t e;
    e.cyc  = cyc + 1;
    e.name = name;
    e.v    = {4'(h), 6'(m), 1'(p), 2'(md), 1'(bh), 1'(bmn), 1'(sc)};
    sb.push_back(e);
  endtask

  // Monitor: compare every snapshot that is due this cycle.
  always @(negedge clk) begin
    logic [15:0] act;
    exp_t        e;
    act = {hours, minutes, pm, mode, blank_hours, blank_minutes, sec_clear};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks = checks + 1;
      if (act !== e.v || e.cyc != cyc) begin
        errors = errors + 1;
        $display("FAIL %s cyc %0d: got h=%0d m=%0d pm=%0d mode=%0d bh=%0d bm=%0d sc=%0d, want h=%0d m=%0d pm=%0d mode=%0d bh=%0d bm=%0d sc=%0d",
                 e.name, cyc, act[15:12], act[11:6], act[5], act[4:3], act[2], act[1], act[0],
                 e.v[15:12], e.v[11:6], e.v[5], e.v[4:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  initial begin
    reset = 1'b0; enable_second = 1'b0; enable_minute = 1'b0;
    btn_mode = 1'b0; btn_inc = 1'b0;

    step(0, 0, 0, 0, 1); exp_o("reset", 12, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);    exp_o("reset_hold", 12, 0, 0, 0, 0, 0, 0);

    // Set 11:00 AM then wrap minutes in SET_MIN.
    step(1, 0, 0, 0);    exp_o("to_set_hour", 12, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      step(0, 1, 0, 0);  exp_o("set_hour_inc", i, 0, 0, 1, 0, 0, 0);
    end
    step(0, 0, 1, 0);    exp_o("set_hour_ignores_min", 11, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0);    exp_o("to_set_min", 11, 0, 0, 2, 0, 0, 0);
    for (int i = 1; i <= 60; i++) begin
      step(0, 1, 0, 0);  exp_o("set_min_inc", 11, (i == 60) ? 0 : i, 0, 2, 0, 0, 0);
    end
    step(0, 0, 1, 0);    exp_o("set_min_ignores_min", 11, 0, 0, 2, 0, 0, 0);
    step(1, 0, 0, 0);    exp_o("exit_set_min_clear", 11, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0);    exp_o("sec_clear_fall", 11, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0);    exp_o("run_ignores_inc", 11, 0, 0, 0, 0, 0, 0);

    // RUN: count to 11:59 AM, roll to 12:00 PM, then to 1:00 PM.
    for (int i = 1; i <= 59; i++) begin
      step(0, 0, 1, 0);  exp_o("run_min", 11, i, 0, 0, 0, 0, 0);
    end
    step(0, 0, 1, 0);    exp_o("run_to_12pm", 12, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 59; i++) begin
      step(0, 0, 1, 0);  exp_o("run_min_pm", 12, i, 1, 0, 0, 0, 0);
    end
    step(0, 0, 1, 0);    exp_o("run_to_1pm", 1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0);    exp_o("mode_with_minute", 1, 1, 1, 1, 0, 0, 0);

    // Hour blink: blanked on odd pulses, holding between pulses.
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1);  exp_o("blink_hours", 1, 1, 1, 1, (k % 2 == 0) ? 1 : 0, 0, 0);
      step(0, 0, 0, 0);  exp_o("blink_hold", 1, 1, 1, 1, (k % 2 == 0) ? 1 : 0, 0, 0);
    end
    for (int i = 2; i <= 11; i++) begin
      step(0, 1, 0, 0);  exp_o("set_hour_pm", i, 1, 1, 1, 0, 0, 0);
    end
    step(0, 1, 0, 0);    exp_o("set_hour_11_to_12", 12, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 0);  exp_o("set_hour_12_to_3", i, 1, 0, 1, 0, 0, 0);
    end

    // enable_second together with btn_mode: new state starts unblanked.
    step(0, 0, 0, 1);    exp_o("blink_before_exit", 3, 1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1);    exp_o("esec_vs_mode", 3, 1, 0, 2, 0, 0, 0);
    step(0, 0, 0, 1);    exp_o("blink_minutes_on", 3, 1, 0, 2, 0, 1, 0);
    step(0, 0, 0, 1);    exp_o("blink_minutes_off", 3, 1, 0, 2, 0, 0, 0);
    step(1, 0, 0, 0);    exp_o("exit_again_clear", 3, 1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0);    exp_o("reenter_set_hour", 3, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0);    exp_o("mode_beats_inc", 3, 1, 0, 2, 0, 0, 0);
    step(0, 0, 0, 1);    exp_o("blink_before_reset", 3, 1, 0, 2, 0, 1, 0);
    step(1, 0, 0, 0, 1); exp_o("reset_mid_set", 12, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);    exp_o("no_clear_after_reset", 12, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expected snapshots never compared, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
